step_dir_gen: RTL and testbench
===============================

Name: step_dir_gen

Overview:
- Generates step/dir pulse trains for one axis from queued motion segments: N steps, fixed period, one direction.
- Sits directly upstream of the step/dir position counter. Its `step`/`dir` outputs drive that counter's inputs, and the driver pins in parallel.
- Guarantees the counter's timing needs: dir stable at least 2 clk before any step rise, step high at least 1 clk, step low at least 1 clk.
- Segments arrive from the bus-side command register via a valid/ready handshake.

Parameters:
- PERIOD_W, 16, width of step period field (clk cycles, rise-to-rise).
- STEPS_W, 16, width of step-count field.
- TIM_W, 8, width of pulse-width and dir-setup fields.

Ports:
- clk  in  1  system clock.
- aclr  in  1  asynchronous reset, active-high.
- sclr  in  1  synchronous clear; same effect as aclr on the next clk edge.
- cfg_pulse_width  in  TIM_W  step high time in clk; latched at command accept.
- cfg_dir_setup  in  TIM_W  dir-to-step setup in clk; latched at command accept.
- cmd_valid  in  1  segment command valid.
- cmd_ready  out  1  block can accept a segment.
- cmd_dir  in  1  direction of the segment (1 = reverse / count down).
- cmd_period  in  PERIOD_W  step rise-to-rise period in clk.
- cmd_steps  in  STEPS_W  number of steps in the segment.
- abort  in  1  terminate the current segment early.
- step  out  1  registered step pulse.
- dir  out  1  registered direction level.
- busy  out  1  a segment is in progress.
- done  out  1  one-clk pulse when a segment ends.
- aborted  out  1  valid with done; 1 if the segment ended by abort.
- steps_left  out  STEPS_W  remaining steps of the current segment.

Behaviour:
- Reset values (aclr, or sclr at the edge): step=0, dir=0, busy=0, done=0, aborted=0, steps_left=0, state=IDLE.
- cmd_ready = (state==IDLE) & ~sclr. It is combinational from state and sclr.
- A command is accepted at a clk edge where cmd_valid & cmd_ready. On accept, latch dir, period, steps, pulse width and dir setup.
- Effective values computed at accept:
  - pw_eff = max(cfg_pulse_width, 1).
  - per_eff = max(cmd_period, pw_eff+1).
  - setup_eff = max(cfg_dir_setup, 2).
- States: IDLE, SETUP, HIGH, LOW.
- IDLE, on accept (edge T):
  - cmd_steps==0: done=1 and aborted=0 in cycle T+1; stay IDLE; dir unchanged.
  - cmd_dir != dir: dir takes the new value at T+1; enter SETUP for setup_eff cycles.
  - cmd_dir == dir: enter HIGH; step=1 at T+1.
- SETUP: down-counts setup_eff; then HIGH. First step rise occurs setup_eff cycles after the dir change.
- HIGH:
  - step=1 for pw_eff cycles.
  - steps_left decrements by 1 in the first HIGH cycle (on the rise).
  - Then LOW.
- LOW:
  - step=0 until per_eff cycles have elapsed since the rise.
  - If steps_left>0: HIGH.
  - Else: IDLE with done=1.
- Last step: done asserts per_eff cycles after its rise. A command accepted that same cycle gives its first rise 1 cycle later, so the segment-boundary gap is per_eff+1.
- dir never changes while busy. busy=1 in SETUP/HIGH/LOW.
- abort (sampled each clk while busy):
  - In SETUP: go to IDLE next cycle with done=1, aborted=1; no step issued.
  - In HIGH: the pulse completes its full pw_eff; then IDLE with done=1, aborted=1 (no LOW wait).
  - In LOW: IDLE next cycle with done=1, aborted=1.
  - steps_left keeps its residual value until the next accept.
  - abort in IDLE is ignored. An accept and abort in the same cycle: the accept wins; abort is re-sampled next cycle.
- Counters use saturating compare, not wrap. A period of max value (2^PERIOD_W-1) must work exactly.
- aclr or sclr mid-pulse: step drops immediately (aclr) or at the next edge (sclr). No done is generated.

Decomposition:
- Package step_dir_pkg holds:
  - the state enum (IDLE, SETUP, HIGH, LOW);
  - localparam MIN_DIR_SETUP = 2 (downstream dir sync depth);
  - localparam MIN_PULSE = 1.
- One sub-module, sd_timer: a loadable down-counter with aclr/sclr, load, and zero flag. It is used for the setup, pulse and period timing.

Test Plan:
- Same dir, pw=3, period=10, steps=4 → 4 rises at T+1, +11, +21, +31. step high 3 clk each. done at T+41. steps_left 4→0.
- dir 0→1, setup=5, steps=1 → dir=1 at T+1, step rise at T+6, no earlier.
- setup=0, pw=0, period=1 → dir leads step by 2 clk, step high 1 clk, rise-to-rise 2 clk (clamped).
- steps=0 → done=1, aborted=0 at T+1; step and dir unchanged; cmd_ready stays 1.
- abort in the 2nd HIGH cycle of step 2 of 5, pw=4 → the pulse completes 4 clk, then done=1, aborted=1, steps_left=3.
- Downstream check: drive step_dir_cnt from the outputs with alternating-dir segments +7/−3/+5 → snapshot count reads 9; aclr mid-pulse → step=0 immediately.

Source files
------------

// File: rtl/step_dir_pkg.sv
// Shared types and constants for the step/dir pulse generator.
//   sd_state_e    : sequencer states (idle, dir setup, step high, step low)
//   MIN_DIR_SETUP : minimum dir-to-step setup; matches the downstream dir synchroniser depth
//   MIN_PULSE     : minimum step high/low time in clk
package step_dir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } sd_state_e;

    localparam int unsigned MIN_DIR_SETUP = 2;
    localparam int unsigned MIN_PULSE     = 1;

endpackage

// File: rtl/sd_timer.sv
// Loadable saturating down-counter used for dir setup, pulse width and period timing.
// Ports:
//   clk_i      : clock
//   aclr_i     : asynchronous clear, active-high
//   sclr_i     : synchronous clear
//   load_i     : load load_val_i on the next edge (has priority over counting)
//   load_val_i : value to load
//   zero_o     : counter is at zero (counting stops there, no wrap)
module sd_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         aclr_i,
    input  logic         sclr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            cnt_q <= '0;
        end else if (sclr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/step_dir_gen.sv
// Step/dir pulse-train generator for one axis.
// Accepts motion segments (N steps, fixed rise-to-rise period, one direction)
// over a valid/ready handshake and produces registered step/dir outputs that
// keep dir stable >= 2 clk before any step rise, step high >= 1 clk and
// step low >= 1 clk.
// Ports:
//   clk, aclr, sclr             : clock, async clear, sync clear
//   cfg_pulse_width, cfg_dir_setup : timing config, latched at command accept
//   cmd_valid/cmd_ready          : segment handshake
//   cmd_dir, cmd_period, cmd_steps : segment fields
//   abort                        : terminate the current segment early
//   step, dir                    : registered outputs to position counter/driver
//   busy, done, aborted          : segment status (done is a 1-clk pulse)
//   steps_left                   : remaining steps of the current segment
module step_dir_gen
    import step_dir_pkg::*;
#(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned STEPS_W  = 16,
    parameter int unsigned TIM_W    = 8
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic                sclr,
    input  logic [TIM_W-1:0]    cfg_pulse_width,
    input  logic [TIM_W-1:0]    cfg_dir_setup,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic                abort,
    output logic                step,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [STEPS_W-1:0]  steps_left
);

    // Period arithmetic needs room for pw_eff+1 even when PERIOD_W is narrow.
    localparam int unsigned CW = (PERIOD_W > TIM_W) ? PERIOD_W : TIM_W + 1;

    sd_state_e          state_q, state_d;
    logic               dir_q, dir_d;
    logic               step_q, step_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               abort_pend_q, abort_pend_d;
    logic [STEPS_W-1:0] steps_left_q, steps_left_d;
    logic [TIM_W-1:0]   pw_q, pw_d;
    logic [CW-1:0]      per_q, per_d;

    logic [TIM_W-1:0]   pw_eff, setup_eff;
    logic [CW-1:0]      per_eff, pw_plus1, period_ext;

    logic               accept;
    logic               ld_a, ld_p;
    logic [TIM_W-1:0]   ld_a_val;
    logic [CW-1:0]      ld_p_val;
    logic               a_zero, p_zero;

    logic               rise;
    logic [TIM_W-1:0]   rise_pw;
    logic [CW-1:0]      rise_per;
    logic [STEPS_W-1:0] rise_steps;

    assign cmd_ready = (state_q == IDLE) & ~sclr;
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        pw_eff     = (cfg_pulse_width < TIM_W'(MIN_PULSE)) ? TIM_W'(MIN_PULSE) : cfg_pulse_width;
        setup_eff  = (cfg_dir_setup < TIM_W'(MIN_DIR_SETUP)) ? TIM_W'(MIN_DIR_SETUP) : cfg_dir_setup;
        pw_plus1   = CW'(pw_eff) + CW'(1);
        period_ext = CW'(cmd_period);
        per_eff    = (period_ext < pw_plus1) ? pw_plus1 : period_ext;
    end

    // Timer A times the dir setup and then the step-high phase; timer P runs
    // from each rise and decides when the next rise (or segment end) happens.
    sd_timer #(.W(TIM_W)) u_tmr_a (
        .clk_i      (clk),
        .aclr_i     (aclr),
        .sclr_i     (sclr),
        .load_i     (ld_a),
        .load_val_i (ld_a_val),
        .zero_o     (a_zero)
    );

    sd_timer #(.W(CW)) u_tmr_p (
        .clk_i      (clk),
        .aclr_i     (aclr),
        .sclr_i     (sclr),
        .load_i     (ld_p),
        .load_val_i (ld_p_val),
        .zero_o     (p_zero)
    );

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        abort_pend_d = abort_pend_q;
        steps_left_d = steps_left_q;
        pw_d         = pw_q;
        per_d        = per_q;
        ld_a         = 1'b0;
        ld_a_val     = '0;
        ld_p         = 1'b0;
        ld_p_val     = '0;
        rise         = 1'b0;
        rise_pw      = pw_q;
        rise_per     = per_q;
        rise_steps   = steps_left_q;

        case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (accept) begin
                    pw_d         = pw_eff;
                    per_d        = per_eff;
                    steps_left_d = cmd_steps;
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else if (cmd_dir != dir_q) begin
                        dir_d    = cmd_dir;
                        state_d  = SETUP;
                        ld_a     = 1'b1;
                        ld_a_val = setup_eff - 1'b1;
                    end else begin
                        // Latched copies are not valid yet, use the live values.
                        rise       = 1'b1;
                        rise_pw    = pw_eff;
                        rise_per   = per_eff;
                        rise_steps = cmd_steps;
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (a_zero) begin
                    rise = 1'b1;
                end
            end
            HIGH: begin
                // An abort during the pulse is remembered so the pulse still
                // completes its full width before the segment ends.
                if (a_zero) begin
                    if (abort || abort_pend_q) begin
                        state_d      = IDLE;
                        done_d       = 1'b1;
                        aborted_d    = 1'b1;
                        abort_pend_d = 1'b0;
                    end else begin
                        state_d = LOW;
                    end
                end else if (abort) begin
                    abort_pend_d = 1'b1;
                end
            end
            LOW: begin
                if (abort) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (p_zero) begin
                    if (steps_left_q != '0) begin
                        rise = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Common step-rise action: both timers restart at the rise and the
        // remaining-step count drops on the rise itself.
        if (rise) begin
            state_d      = HIGH;
            ld_a         = 1'b1;
            ld_a_val     = rise_pw - 1'b1;
            ld_p         = 1'b1;
            ld_p_val     = rise_per - 1'b1;
            steps_left_d = rise_steps - 1'b1;
        end

        step_d = (state_d == HIGH);
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            steps_left_q <= '0;
            pw_q         <= '0;
            per_q        <= '0;
        end else if (sclr) begin
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            steps_left_q <= '0;
            pw_q         <= '0;
            per_q        <= '0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            steps_left_q <= steps_left_d;
            pw_q         <= pw_d;
            per_q        <= per_d;
        end
    end

    assign step       = step_q;
    assign dir        = dir_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign steps_left = steps_left_q;

endmodule

// File: tb/tb_step_dir_gen.sv
// Self-checking bench for step_dir_gen: directed cases plus randomized segments
// checked cycle by cycle against an arithmetic timeline model.
module tb_step_dir_gen;

    logic        clk = 1'b0;
    logic        aclr, sclr;
    logic [7:0]  cfg_pulse_width, cfg_dir_setup;
    logic        cmd_valid, cmd_ready, cmd_dir;
    logic [15:0] cmd_period, cmd_steps;
    logic        abort;
    logic        step, dir, busy, done, aborted;
    logic [15:0] steps_left;

    int checks   = 0;
    int failures = 0;
    bit m_dir    = 1'b0;

    logic step_p  = 1'b0;
    int   pos_cnt = 0;

    always #5 clk = ~clk;

    step_dir_gen #(.PERIOD_W(16), .STEPS_W(16), .TIM_W(8)) dut (
        .clk             (clk),
        .aclr            (aclr),
        .sclr            (sclr),
        .cfg_pulse_width (cfg_pulse_width),
        .cfg_dir_setup   (cfg_dir_setup),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_dir         (cmd_dir),
        .cmd_period      (cmd_period),
        .cmd_steps       (cmd_steps),
        .abort           (abort),
        .step            (step),
        .dir             (dir),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .steps_left      (steps_left)
    );

    // Position counter as the downstream block would see it.
    always @(negedge clk) begin
        if (step === 1'b1 && step_p === 1'b0) pos_cnt = dir ? pos_cnt - 1 : pos_cnt + 1;
        step_p = step;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input bit d, input int per, input int n, input int pw, input int su);
        cmd_valid       = 1'b1;
        cmd_dir         = d;
        cmd_period      = 16'(per);
        cmd_steps       = 16'(n);
        cfg_pulse_width = 8'(pw);
        cfg_dir_setup   = 8'(su);
    endtask

    // Called at a negedge; returns at the negedge of the done cycle so a
    // following call is accepted back-to-back.
    task automatic run_seg(input bit d, input int per, input int n, input int pw, input int su,
                           input bit ab_at_accept);
        int pwe, pere, se, s0, done_k, j, off;
        int e_step, e_busy, e_done, e_sl, e_rdy;
        pwe    = (pw == 0) ? 1 : pw;
        pere   = (per < pwe + 1) ? pwe + 1 : per;
        se     = (su < 2) ? 2 : su;
        s0     = (n != 0 && d != m_dir) ? se : 0;
        done_k = (n == 0) ? 1 : 1 + s0 + n * pere;
        drive_cmd(d, per, n, pw, su);
        abort = ab_at_accept;
        chk("ready_at_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        if (n != 0) m_dir = d;
        for (int k = 1; k <= done_k; k++) begin
            @(negedge clk);
            if (k == done_k) begin
                e_step = 0; e_busy = 0; e_done = 1; e_sl = 0; e_rdy = 1;
            end else begin
                e_busy = 1; e_done = 0; e_rdy = 0;
                if (k < 1 + s0) begin
                    e_step = 0; e_sl = n;
                end else begin
                    j      = (k - 1 - s0) / pere;
                    off    = (k - 1 - s0) % pere;
                    e_step = (off < pwe) ? 1 : 0;
                    e_sl   = n - j - 1;
                end
            end
            chk($sformatf("step@%0d", k), step, e_step);
            chk($sformatf("dir@%0d", k), dir, m_dir);
            chk($sformatf("busy@%0d", k), busy, e_busy);
            chk($sformatf("done@%0d", k), done, e_done);
            chk($sformatf("aborted@%0d", k), aborted, 0);
            chk($sformatf("steps_left@%0d", k), steps_left, e_sl);
            chk($sformatf("ready@%0d", k), cmd_ready, e_rdy);
        end
    endtask

    initial begin
        int snap;
        aclr = 1'b1; sclr = 1'b0; abort = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0;
        cmd_period = '0; cmd_steps = '0; cfg_pulse_width = '0; cfg_dir_setup = '0;
        @(negedge clk);
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_steps_left", steps_left, 0);
        chk("rst_ready", cmd_ready, 1);
        @(negedge clk);
        aclr = 1'b0;
        @(negedge clk);

        // Basic: 4 steps, pw 3, period 10, same dir.
        run_seg(m_dir, 10, 4, 3, 0, 1'b0);
        // Dir change with setup 5, single step.
        run_seg(~m_dir, 20, 1, 2, 5, 1'b0);
        // Everything clamped: setup 2, pw 1, period 2.
        run_seg(~m_dir, 1, 3, 0, 0, 1'b0);
        // Zero-step command with a different dir leaves dir alone.
        run_seg(~m_dir, 5, 0, 2, 3, 1'b0);
        // Accept and abort in the same cycle: accept wins, segment runs normally.
        run_seg(m_dir, 5, 2, 2, 0, 1'b1);

        // Abort in the 2nd HIGH cycle of step 2 of 5.
        drive_cmd(m_dir, 10, 5, 4, 0);
        @(posedge clk); #1; cmd_valid = 1'b0;
        repeat (11) @(negedge clk);
        chk("ab_hi_rise2", step, 1);
        chk("ab_hi_sl_rise2", steps_left, 3);
        @(negedge clk);
        chk("ab_hi_k12_step", step, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_hi_k13_step", step, 1);
        chk("ab_hi_k13_busy", busy, 1);
        @(negedge clk);
        chk("ab_hi_k14_step", step, 1);
        chk("ab_hi_k14_done", done, 0);
        @(negedge clk);
        chk("ab_hi_k15_step", step, 0);
        chk("ab_hi_k15_done", done, 1);
        chk("ab_hi_k15_aborted", aborted, 1);
        chk("ab_hi_k15_busy", busy, 0);
        chk("ab_hi_k15_sl", steps_left, 3);
        @(negedge clk);
        chk("ab_hi_k16_done", done, 0);
        chk("ab_hi_k16_sl", steps_left, 3);

        // Abort during dir setup: no step, residual count kept.
        drive_cmd(~m_dir, 10, 3, 2, 5);
        @(posedge clk); #1; cmd_valid = 1'b0; m_dir = ~m_dir;
        @(negedge clk);
        chk("ab_su_k1_dir", dir, m_dir);
        chk("ab_su_k1_step", step, 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_su_done", done, 1);
        chk("ab_su_aborted", aborted, 1);
        chk("ab_su_step", step, 0);
        chk("ab_su_busy", busy, 0);
        chk("ab_su_sl", steps_left, 3);
        chk("ab_su_dir", dir, m_dir);

        // Abort in LOW.
        drive_cmd(m_dir, 8, 3, 2, 0);
        @(posedge clk); #1; cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("ab_lo_k4_step", step, 0);
        chk("ab_lo_k4_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_lo_done", done, 1);
        chk("ab_lo_aborted", aborted, 1);
        chk("ab_lo_sl", steps_left, 2);

        // Abort while idle is ignored.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_idle_done", done, 0);
        chk("ab_idle_busy", busy, 0);

        // Randomized segments, random idle gaps (0 = back-to-back).
        for (int i = 0; i < 16; i++) begin
            run_seg(1'($urandom_range(0, 1)), int'($urandom_range(0, 24)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Maximum period must time exactly.
        run_seg(m_dir, 65535, 1, 3, 0, 1'b0);

        // Downstream count over +7 / -3 / +5.
        snap = pos_cnt;
        run_seg(1'b0, 6, 7, 2, 3, 1'b0);
        run_seg(1'b1, 6, 3, 2, 3, 1'b0);
        run_seg(1'b0, 6, 5, 2, 3, 1'b0);
        chk("down_count", pos_cnt - snap, 9);

        // sclr mid-pulse: clears on the next edge, no done.
        drive_cmd(1'b1, 6, 3, 3, 2);
        @(posedge clk); #1; cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sclr_pre_step", step, 1);
        sclr = 1'b1;
        #1;
        chk("sclr_ready", cmd_ready, 0);
        @(negedge clk);
        sclr = 1'b0;
        m_dir = 1'b0;
        chk("sclr_step", step, 0);
        chk("sclr_dir", dir, 0);
        chk("sclr_busy", busy, 0);
        chk("sclr_done", done, 0);
        chk("sclr_sl", steps_left, 0);
        @(negedge clk);
        chk("sclr_done_after", done, 0);

        // aclr mid-pulse: step drops immediately.
        drive_cmd(m_dir, 10, 2, 5, 0);
        @(posedge clk); #1; cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("aclr_pre_step", step, 1);
        aclr = 1'b1;
        #1;
        chk("aclr_step", step, 0);
        chk("aclr_busy", busy, 0);
        chk("aclr_sl", steps_left, 0);
        @(negedge clk);
        aclr = 1'b0;
        @(negedge clk);
        chk("aclr_done", done, 0);
        chk("aclr_dir", dir, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
